uart_rx_core: RTL and testbench
===============================

# uart_rx_core

UART receiver for the board-level serial port: samples the asynchronous `rxd` pin, recovers 8N1 frames (8 data bits, no parity, 1 stop bit) at 16x oversampling, and presents each received byte on a valid/ready handshake. It is the receive-side counterpart of the design's `txd` transmitter and feeds the command/debug path inside the top module. It also reports framing and overrun errors.

## Interface
- `CLKS_PER_TICK`, 54: `clk` cycles per oversample tick. 100 MHz / (115200 × 16) gives 54.
- `OVERSAMPLE`, 16: ticks per bit period. Fixed at 16; other values are unsupported.
- `DATA_BITS`, 8: data bits per frame.
- `clk`  in  1  system clock (100 MHz).
- `rst_n`  in  1  asynchronous, active-low reset.
- `rxd`  in  1  serial input. Asynchronous to `clk`; idles high.
- `rx_data`  out  8  received byte. Stable while `rx_valid`=1.
- `rx_valid`  out  1  byte available.
- `rx_ready`  in  1  consumer accepts the byte.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples low.
- `overrun`  out  1  one-cycle pulse when a completed byte is dropped.
- `busy`  out  1  high in every state except IDLE and ARM.

## Operation
- **Input synchronization:** `rxd` passes through a 2-flop synchronizer to give `rxd_s`. Both flops reset to 1.
- **Tick counter:**
  - Counts 0..CLKS_PER_TICK-1 and emits a one-cycle `tick` at the terminal count.
  - Cleared when start detection enters START, so bit sampling is phase-aligned to the falling edge.
- **Sample counter:** 4-bit counter `scnt`, advanced on each `tick` and wrapping 15→0.
- **Majority vote:** `rxd_s` is captured on the ticks where `scnt` = 7, 8 and 9. The bit value is the majority of the 3 samples, decided at `scnt`=9.
- **State machine:**
  - ARM (reset state): wait for `rxd_s`=1, then go to IDLE. This prevents locking onto a frame that was already in progress at reset.
  - IDLE: when `rxd_s`=0, clear the tick counter and `scnt`, then go to START.
  - START: at the vote, bit=1 is a false start and returns to IDLE with no error. Bit=0 goes to DATA once `scnt` wraps. `bit_idx` is set to 0.
  - DATA: each vote shifts the bit into the shift register LSB-first. After bit `DATA_BITS-1`, go to STOP at the `scnt` wrap.
  - STOP: at the vote, bit=1 is a good frame and bit=0 pulses `frame_err` and discards the byte. In either case go to IDLE immediately, without waiting for the end of the stop bit, so back-to-back frames are supported.
- **Output register** (one entry), updated on a good frame:
  - If `rx_valid`=0, or `rx_ready`=1 in the same cycle: load `rx_data` and set `rx_valid`=1.
  - Otherwise pulse `overrun`, drop the new byte and keep the old one.
  - `rx_ready`=1 with no new byte clears `rx_valid`.
- **Reset mid-frame:** all state is abandoned. The block restarts in ARM and delivers no partial byte.

## Timing
- **Reset values:** `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0, `parity_err`=0. The synchronizer flops are 1.
- **Bit period:** 16 × `CLKS_PER_TICK` clocks.
- **Detection latency:** the falling edge at the pin reaches IDLE detection 2–3 clocks later.
- **Byte latency:** `rx_valid` rises on the clock after the stop-bit vote. That is about 9.56 bit periods (9 bits + 9/16 of the stop bit) after the start edge, plus 3 clocks.
- **Error flags:** `frame_err` and `overrun` are single-cycle pulses and are never asserted together.
- **Handshake:** a transfer completes on any rising edge where `rx_valid` and `rx_ready` are both 1. `rx_data` does not change while `rx_valid`=1 and `rx_ready`=0.

## Configuration
- **`UART_RX_PARITY_EN` defined:**
  - A PARITY state is inserted between DATA and STOP and checks even parity over the data plus parity bits.
  - On mismatch, the block pulses the output `parity_err` (1 bit) and discards the byte. The frame still proceeds to STOP.
  - If both errors occur, `frame_err` takes priority and `parity_err` is suppressed.
- **Not defined:** there is no PARITY state, and the `parity_err` port is absent.

## Structure
- **Package `uart_pkg`:**
  - State enum covering ARM, IDLE, START, DATA, PARITY and STOP.
  - Sample constants `SAMPLE_A`=7, `SAMPLE_B`=8, `SAMPLE_C`=9.
  - `OVERSAMPLE` constant.
- **Sub-module `uart_tick_gen`:** the tick counter, with a `clear` input and a `tick` output. The future transmitter reuses it.

## Test plan
All scenarios use `CLKS_PER_TICK`=4, giving a 64-clock bit period.
- **Basic receive:** drive 0xA5 as 8N1 with `rx_ready`=1 → `rx_valid` pulses once with `rx_data`=0xA5. The pulse comes 612±3 clocks after the start edge.
- **False start:** a 0.25-bit low glitch (16 clocks) → no `rx_valid`, no `frame_err`, and `busy` returns to 0 within 40 clocks.
- **Framing error:** 0x3C sent with stop bit=0 → `frame_err` pulses exactly 1 cycle and `rx_valid` stays 0. A following 0x55 then receives correctly.
- **Overrun:** send 0x11 and then 0x22 back-to-back with `rx_ready`=0 → `overrun` pulses and `rx_data` stays 0x11. After `rx_ready`=1, `rx_valid` drops the next cycle.
- **Reset mid-frame:** assert `rst_n`=0 for 5 clocks after data bit 3 of 0xF0, with `rxd` still driving the frame → no byte is delivered. The next full frame 0x81 is received correctly.
- **Noise rejection:** flip `rxd` for 1 clock at the center of each data bit of 0x5A → `rx_data`=0x5A, because the majority vote rejects the glitches.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART blocks: receiver state encoding,
// oversampling constants and the 3-sample majority vote.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_ARM,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam int OVERSAMPLE = 16;

    localparam logic [3:0] SAMPLE_A = 4'd7;
    localparam logic [3:0] SAMPLE_B = 4'd8;
    localparam logic [3:0] SAMPLE_C = 4'd9;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: one-cycle tick every CLKS_PER_TICK clocks,
// restartable with clear so the tick phase can follow an external event.
module uart_tick_gen #(
    parameter int CLKS_PER_TICK = 54
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);
    localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_TICK - 1);

    logic [CW-1:0] cnt;

    // Down-counter: the terminal count at zero is the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RELOAD;
        end else if (clear || (cnt == '0)) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0) && !clear;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with 16x oversampling, majority-vote bit decisions and a
// one-entry valid/ready output. Define UART_RX_PARITY_EN for an even-parity bit.
module uart_rx_core #(
    parameter int CLKS_PER_TICK = 54,
    parameter int OVERSAMPLE    = uart_pkg::OVERSAMPLE,
    parameter int DATA_BITS     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);
    import uart_pkg::*;

    // state  | meaning
    // ARM    | after reset, wait for an idle-high line
    // IDLE   | wait for a falling edge on rxd_s
    // START  | validate the start bit (high vote = false start)
    // DATA   | shift in data bits, LSB first
    // PARITY | check even parity over data + parity bit
    // STOP   | check stop bit, deliver or drop the byte

    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic [3:0]    SCNT_WRAP = 4'(OVERSAMPLE - 1);

    rx_state_t            state;
    logic                 sync_1, rxd_s;
    logic                 tick, tick_clear;
    logic [3:0]           scnt, scnt_nxt;
    logic                 samp_a, samp_b, vote;
    logic                 at_a, at_b, at_c, at_wrap;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            rxd_s  <= 1'b1;
        end else begin
            sync_1 <= rxd;
            rxd_s  <= sync_1;
        end
    end

    assign tick_clear = (state == ST_IDLE) && !rxd_s;

    uart_tick_gen #(
        .CLKS_PER_TICK(CLKS_PER_TICK)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(tick_clear),
        .tick (tick)
    );

    // Sample points are named by the scnt value the tick advances into.
    assign scnt_nxt = scnt + 4'd1;
    assign at_a     = tick && (scnt_nxt == SAMPLE_A);
    assign at_b     = tick && (scnt_nxt == SAMPLE_B);
    assign at_c     = tick && (scnt_nxt == SAMPLE_C);
    assign at_wrap  = tick && (scnt == SCNT_WRAP);
    assign vote     = majority3(samp_a, samp_b, rxd_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ARM;
            scnt      <= 4'd0;
            samp_a    <= 1'b1;
            samp_b    <= 1'b1;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            par_bad    <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (rx_ready) rx_valid <= 1'b0;
            if (tick) scnt <= scnt_nxt;
            if (at_a) samp_a <= rxd_s;
            if (at_b) samp_b <= rxd_s;

            case (state)
                ST_ARM: begin
                    if (rxd_s) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (!rxd_s) begin
                        state <= ST_START;
                        scnt  <= 4'd0;
                        busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (at_c && vote) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (at_wrap) begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (at_c) shreg <= {vote, shreg[DATA_BITS-1:1]};
                    if (at_wrap) begin
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (at_c) par_bad <= (^shreg) ^ vote;
                    if (at_wrap) state <= ST_STOP;
                end
`endif
                ST_STOP: begin
                    // Leave at the vote so a back-to-back start edge is not missed.
                    if (at_c) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        if (!vote) begin
                            frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (par_bad) begin
                            parity_err <= 1'b1;
`endif
                        end else if (rx_valid && !rx_ready) begin
                            overrun <= 1'b1;
                        end else begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_ARM;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at CLKS_PER_TICK=4 (64-clock bit period).
module tb_uart_rx_core;
    localparam int CPT = 4;
    localparam int BIT = 16 * CPT;
`ifdef UART_RX_PARITY_EN
    localparam int LAT_NOM = 612 + BIT;
`else
    localparam int LAT_NOM = 612;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_rises = 0;
    int ferr_cycles = 0;
    int ovr_cycles = 0;
    int both_cycles = 0;
    logic       valid_q = 1'b0;
    logic [7:0] last_byte = 8'h00;

    uart_rx_core #(
        .CLKS_PER_TICK(CPT),
        .OVERSAMPLE   (16),
        .DATA_BITS    (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rxd      (rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && !valid_q) begin
            valid_rises = valid_rises + 1;
            last_byte   = rx_data;
        end
        valid_q = rx_valid;
        if (frame_err) ferr_cycles = ferr_cycles + 1;
        if (overrun) ovr_cycles = ovr_cycles + 1;
        if (frame_err && overrun) both_cycles = both_cycles + 1;
    end

    task automatic send_bit(input logic v, input bit noise);
        for (int i = 0; i < BIT; i++) begin
            rxd = (noise && (i == BIT / 2)) ? ~v : v;
            @(negedge clk);
        end
        rxd = v;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input bit noise);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], noise);
`ifdef UART_RX_PARITY_EN
        send_bit(^d, 1'b0);
`endif
        send_bit(stop, 1'b0);
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rxd = 1'b1;
        rx_ready = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        checks++;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        int t0, lat, r0, f0;
        bit seen;
        logic [7:0] got;
        logic after;
        rx_ready = 1'b1;
        r0 = valid_rises;
        f0 = ferr_cycles;
        seen = 1'b0;
        lat = 0;
        got = 8'h00;
        after = 1'b1;
        t0 = cyc;
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                for (int i = 0; i < 800 && !seen; i++) begin
                    @(negedge clk);
                    if (rx_valid) begin
                        seen = 1'b1;
                        lat = cyc - t0;
                        got = rx_data;
                    end
                end
                if (seen) begin
                    @(negedge clk);
                    after = rx_valid;
                end
            end
        join
        repeat (BIT) @(negedge clk);
        checks++;
        if (!seen) begin errors++; $display("FAIL basic_timeout: rx_valid not seen within 800 clocks"); end
        checks++;
        if (lat < LAT_NOM - 3 || lat > LAT_NOM + 3) begin
            errors++; $display("FAIL basic_latency: got %0d expected %0d..%0d", lat, LAT_NOM - 3, LAT_NOM + 3);
        end
        checks++;
        if (got !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", got); end
        checks++;
        if (after !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: rx_valid %b one cycle later, expected 0", after); end
        checks++;
        if (valid_rises - r0 != 1) begin errors++; $display("FAIL basic_valid_count: got %0d expected 1", valid_rises - r0); end
        checks++;
        if (ferr_cycles != f0) begin errors++; $display("FAIL basic_frame_err: got %0d pulses expected 0", ferr_cycles - f0); end
    endtask

    task automatic test_false_start();
        int r0, f0;
        r0 = valid_rises;
        f0 = ferr_cycles;
        rxd = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL false_start_detect: busy %b expected 1", busy); end
        repeat (6) @(negedge clk);
        rxd = 1'b1;
        repeat (24) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL false_start_busy: busy %b at 40 clocks expected 0", busy); end
        repeat (2 * BIT) @(negedge clk);
        checks++;
        if (valid_rises != r0) begin errors++; $display("FAIL false_start_valid: got %0d bytes expected 0", valid_rises - r0); end
        checks++;
        if (ferr_cycles != f0) begin errors++; $display("FAIL false_start_frame_err: got %0d expected 0", ferr_cycles - f0); end
    endtask

    task automatic test_frame_err();
        int r0, f0;
        rx_ready = 1'b1;
        r0 = valid_rises;
        f0 = ferr_cycles;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        checks++;
        if (ferr_cycles - f0 != 1) begin errors++; $display("FAIL frame_err_cycles: got %0d expected 1", ferr_cycles - f0); end
        checks++;
        if (valid_rises != r0) begin errors++; $display("FAIL frame_err_valid: got %0d bytes expected 0", valid_rises - r0); end
        send_frame(8'h55, 1'b1, 1'b0);
        repeat (BIT) @(negedge clk);
        checks++;
        if (valid_rises - r0 != 1) begin errors++; $display("FAIL frame_err_recover_count: got %0d expected 1", valid_rises - r0); end
        checks++;
        if (last_byte !== 8'h55) begin errors++; $display("FAIL frame_err_recover_data: got %h expected 55", last_byte); end
    endtask

    task automatic test_overrun();
        int r0, o0;
        rx_ready = 1'b0;
        r0 = valid_rises;
        o0 = ovr_cycles;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        repeat (BIT / 2) @(negedge clk);
        checks++;
        if (ovr_cycles - o0 != 1) begin errors++; $display("FAIL overrun_cycles: got %0d expected 1", ovr_cycles - o0); end
        checks++;
        if (rx_data !== 8'h11) begin errors++; $display("FAIL overrun_data: got %h expected 11", rx_data); end
        checks++;
        if (rx_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid_held: got %b expected 1", rx_valid); end
        checks++;
        if (valid_rises - r0 != 1) begin errors++; $display("FAIL overrun_valid_count: got %0d expected 1", valid_rises - r0); end
        rx_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL overrun_drain: rx_valid %b expected 0", rx_valid); end
    endtask

    task automatic test_reset_mid();
        int r0;
        rx_ready = 1'b1;
        r0 = valid_rises;
        fork
            send_frame(8'hF0, 1'b1, 1'b0);
            begin
                repeat (5 * BIT) @(negedge clk);
                rst_n = 1'b0;
                repeat (5) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        repeat (BIT) @(negedge clk);
        checks++;
        if (valid_rises != r0) begin errors++; $display("FAIL reset_mid_valid: got %0d bytes expected 0", valid_rises - r0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b expected 0", busy); end
        send_frame(8'h81, 1'b1, 1'b0);
        repeat (BIT) @(negedge clk);
        checks++;
        if (valid_rises - r0 != 1) begin errors++; $display("FAIL reset_mid_next_count: got %0d expected 1", valid_rises - r0); end
        checks++;
        if (last_byte !== 8'h81) begin errors++; $display("FAIL reset_mid_next_data: got %h expected 81", last_byte); end
    endtask

    task automatic test_noise();
        int r0, f0;
        rx_ready = 1'b1;
        r0 = valid_rises;
        f0 = ferr_cycles;
        send_frame(8'h5A, 1'b1, 1'b1);
        repeat (BIT) @(negedge clk);
        checks++;
        if (valid_rises - r0 != 1) begin errors++; $display("FAIL noise_count: got %0d expected 1", valid_rises - r0); end
        checks++;
        if (last_byte !== 8'h5A) begin errors++; $display("FAIL noise_data: got %h expected 5a", last_byte); end
        checks++;
        if (ferr_cycles != f0) begin errors++; $display("FAIL noise_frame_err: got %0d expected 0", ferr_cycles - f0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        test_noise();
        checks++;
        if (both_cycles != 0) begin errors++; $display("FAIL flags_exclusive: got %0d overlapping cycles expected 0", both_cycles); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
